// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetcher: buffer entry layout and fetch FSM states.
package fetch_pkg;

    typedef struct packed {
        logic        fault;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous clear; the head word is presented combinationally.
module sync_fifo #(
    parameter int BW          = 33,
    parameter int FF_SIZE_POT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_wrEn,
    input  logic [BW-1:0]        i_wrData,
    input  logic                 i_rdEn,
    output logic [BW-1:0]        o_rdData,
    output logic                 o_empty,
    output logic [FF_SIZE_POT:0] o_count
);
    localparam int CW = FF_SIZE_POT + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(2 ** FF_SIZE_POT);

    logic [BW-1:0]          r_mem [2 ** FF_SIZE_POT];
    logic [FF_SIZE_POT-1:0] r_wrPtr;
    logic [FF_SIZE_POT-1:0] r_rdPtr;
    logic [CW-1:0]          r_count;

    logic w_full;
    logic w_doRd;
    logic w_doWr;

    assign w_full   = (r_count == DEPTH_L);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdData = r_mem[r_rdPtr];
    assign w_doRd   = i_rdEn & ~o_empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign w_doWr   = i_wrEn & (~w_full | w_doRd);

    always_ff @(posedge i_clk) begin
        if (w_doWr && !i_clr) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRd) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doWr, w_doRd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_prefetch_ctl.sv
// Pipelined Wishbone instruction prefetcher feeding the core front-end through a small buffer.
// Useful and ignored in-flight requests are counted separately so a redirect never waits for the bus to drain.
module wb_prefetch_ctl
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_PC         = 32'h8000_0000,
    parameter int          BUF_DEPTH_POT   = 3,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [29:0] wb_addr_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        flush_i
);
    localparam int CW  = BUF_DEPTH_POT + 1;
    localparam int CWP = CW + 1;
    localparam logic [CW:0] DEPTH_L = CWP'(2 ** BUF_DEPTH_POT);
    localparam logic [CW:0] MAX_L   = CWP'(MAX_OUTSTANDING);

    fetch_state_t  r_state;
    logic [CW-1:0] r_pending;
    logic [CW-1:0] r_ignore;
    logic [29:0]   r_fetchWord;
    logic [31:0]   r_pc;

    fetch_entry_t  w_head;
    fetch_entry_t  w_wrEntry;
    logic [CW-1:0] w_fill;
    logic          w_empty;
    logic          w_creditOk;
    logic          w_stb;
    logic          w_accept;
    logic          w_resp;
    logic          w_respIgnored;
    logic          w_respUseful;
    logic          w_restart;
    logic          w_consume;
    logic          w_fifoWr;
    logic          w_usefulErr;
    logic [31:0]   w_targetPc;
    logic [CW-1:0] w_outstandingNext;

    // Buffer space is reserved for every useful request in flight, so an ack can never overflow it.
    assign w_creditOk = ((CWP'(r_pending) + CWP'(w_fill)) < DEPTH_L) &&
                        ((CWP'(r_pending) + CWP'(r_ignore)) < MAX_L);
    assign w_stb      = (r_state == S_FETCH) && w_creditOk;
    assign w_accept   = w_stb & ~wb_stall_i;

    assign w_resp        = wb_ack_i | wb_err_i;
    assign w_respIgnored = w_resp && (r_ignore != '0);
    assign w_respUseful  = w_resp && (r_ignore == '0) && (r_pending != '0);
    assign w_restart     = redirect_i | flush_i;
    assign w_targetPc    = redirect_i ? redirect_pc_i : r_pc;
    assign w_consume     = ~w_empty & ~stall_i;
    assign w_fifoWr      = w_respUseful & ~w_restart;
    assign w_usefulErr   = w_fifoWr & wb_err_i;

    assign w_outstandingNext = r_ignore + r_pending + CW'(w_accept)
                               - CW'(w_respIgnored | w_respUseful);

    assign w_wrEntry.fault = wb_err_i;
    assign w_wrEntry.instr = wb_err_i ? 32'h0 : wb_rdata_i;

    sync_fifo #(
        .BW          ($bits(fetch_entry_t)),
        .FF_SIZE_POT (BUF_DEPTH_POT)
    ) u_buf (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clr    (w_restart),
        .i_wrEn   (w_fifoWr),
        .i_wrData (w_wrEntry),
        .i_rdEn   (w_consume),
        .o_rdData (w_head),
        .o_empty  (w_empty),
        .o_count  (w_fill)
    );

    // On restart or a useful error every in-flight request becomes one whose response is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_ignore    <= '0;
            r_fetchWord <= BOOT_PC[31:2];
            r_pc        <= BOOT_PC;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: if (w_usefulErr) r_state <= S_HALT;
                S_HALT:  if (w_restart) r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase

            if (w_restart || w_usefulErr) begin
                r_pending <= '0;
                r_ignore  <= w_outstandingNext;
            end else begin
                r_pending <= r_pending + CW'(w_accept) - CW'(w_respUseful);
                r_ignore  <= r_ignore - CW'(w_respIgnored);
            end

            if (w_restart) begin
                r_fetchWord <= w_targetPc[31:2];
            end else if (w_accept) begin
                r_fetchWord <= r_fetchWord + 30'd1;
            end

            if (w_restart) begin
                r_pc <= w_targetPc;
            end else if (w_consume) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((CWP'(r_pending) + CWP'(r_ignore)) <= MAX_L);
        end
    end

    assign wb_cyc_o  = (r_state == S_FETCH) || (r_pending != '0) || (r_ignore != '0);
    assign wb_stb_o  = w_stb;
    assign wb_addr_o = r_fetchWord;
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = 4'hf;

    assign valid_o = ~w_empty;
    assign fault_o = ~w_empty & w_head.fault;
    assign instr_o = (~w_empty & ~w_head.fault) ? w_head.instr : 32'h0;
    assign pc_o    = r_pc;

endmodule
